// File: rtl/casino_pkg.sv
// Shared types for the casino turn arbiter: FSM state encoding and game result codes.
package casino_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_ROLL,
    ST_ROLL,
    ST_SETTLE,
    ST_SCORE,
    ST_CLEAR,
    ST_DONE
  } state_t;

  localparam logic [1:0] SEL_WIN  = 2'b01;
  localparam logic [1:0] SEL_LOSE = 2'b10;
  localparam logic [1:0] SEL_IDLE = 2'b11;
endpackage

// File: rtl/casino_btn_edge.sv
// Registered rising-edge detector for one debounced, synchronous button level.
module casino_btn_edge
  import casino_pkg::*;
(
  input  logic CLK,
  input  logic Reset,
  input  logic btn,
  output logic rise
);
  logic btn_q;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) btn_q <= 1'b0;
    else       btn_q <= btn;
  end

  assign rise = btn & ~btn_q;
endmodule

// File: rtl/casino_turn_arbiter.sv
// Two-player turn arbiter: gates roll requests, latches dice, waits for the game
// result to settle, keeps match score and reports the winner.
module casino_turn_arbiter
  import casino_pkg::*;
#(
  parameter logic [3:0] WIN_LIMIT  = 4'd5,
  parameter int         SETTLE_CYC = 4
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       btn_p0,
  input  logic       btn_p1,
  input  logic       new_match,
  input  logic [1:0] sel_in,
  output logic       game_rb,
  output logic       game_reset,
  output logic [7:0] q_out,
  output logic       active_player,
  output logic [3:0] score0,
  output logic [3:0] score1,
  output logic       busy,
  output logic       match_done,
  output logic       winner
);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

  state_t     state;
  logic [7:0] dice_cnt;
  logic [7:0] settle_cnt;
  logic [1:0] btn_v;
  logic [1:0] rise;

  assign btn_v = {btn_p1, btn_p0};

  for (genvar i = 0; i < 2; i++) begin : g_edge
    casino_btn_edge u_edge (
      .CLK   (CLK),
      .Reset (Reset),
      .btn   (btn_v[i]),
      .rise  (rise[i])
    );
  end

  // Free-running dice source; its value at the accepted edge is the roll.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) dice_cnt <= 8'h00;
    else       dice_cnt <= dice_cnt + 8'h01;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state         <= ST_IDLE;
      score0        <= 4'd0;
      score1        <= 4'd0;
      active_player <= 1'b0;
      q_out         <= 8'h00;
      winner        <= 1'b0;
      settle_cnt    <= 8'h00;
      game_reset    <= 1'b0;
    end else begin
      // Game reset pulse follows the IDLE and CLEAR cycles by one clock.
      game_reset <= (state == ST_IDLE) || (state == ST_CLEAR);
      case (state)
        ST_IDLE: begin
          active_player <= 1'b0;
          state         <= ST_WAIT_ROLL;
        end
        ST_WAIT_ROLL: begin
          if (rise[active_player]) begin
            q_out <= dice_cnt;
            state <= ST_ROLL;
          end
        end
        ST_ROLL: begin
          settle_cnt <= 8'h00;
          state      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) state <= ST_SCORE;
          else                           settle_cnt <= settle_cnt + 8'h01;
        end
        ST_SCORE: begin
          case (sel_in)
            SEL_WIN: begin
              if (active_player) score1 <= score1 + 4'd1;
              else               score0 <= score0 + 4'd1;
              state <= ST_CLEAR;
            end
            SEL_LOSE: begin
              if (active_player) score0 <= score0 + 4'd1;
              else               score1 <= score1 + 4'd1;
              state <= ST_CLEAR;
            end
            default: state <= ST_WAIT_ROLL;
          endcase
        end
        ST_CLEAR: begin
          active_player <= ~active_player;
          if ((score0 == WIN_LIMIT) || (score1 == WIN_LIMIT)) begin
            winner <= (score1 == WIN_LIMIT);
            state  <= ST_DONE;
          end else begin
            state <= ST_WAIT_ROLL;
          end
        end
        ST_DONE: begin
          if (new_match) begin
            score0 <= 4'd0;
            score1 <= 4'd0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign game_rb    = (state == ST_ROLL);
  assign busy       = (state == ST_ROLL) || (state == ST_SETTLE);
  assign match_done = (state == ST_DONE);
endmodule
